inst_fetch_unit: RTL and testbench

- Decoupled instruction-fetch front end sitting directly upstream of the core datapath; supplies instruction word, its PC and PC+4 to decode/register-read.
- Issues sequential requests to an external instruction memory with variable (≥1 cycle), in-order response latency.
- Buffers returned words in a small FIFO; drains on core ready.
- Supports a single-cycle redirect (branch/jump/jr target) that flushes buffered and in-flight fetches.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_if.sv | 31 +++
 rtl/inst_fetch_unit_fifo.sv | 51 +++++
 rtl/inst_fetch_unit.sv | 96 +++++++++
 tb/tb_inst_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction fetch front end.
package fetch_pkg;

    localparam int          DEFAULT_DATA_W = 32;
    localparam logic [31:0] FETCH_PC_INC   = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch unit.
interface inst_fetch_unit_if #(
    parameter int DATA_W = fetch_pkg::DEFAULT_DATA_W
);
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [DATA_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [DATA_W-1:0] inst_pc;
    logic [DATA_W-1:0] inst_next_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
               inst_next_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc,
               inst_next_pc
    );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous FIFO with flush; head is read straight from registered storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int CW    = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign dout   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && count == CW'(DEPTH)));
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Decoupled fetch front end: credit-limited sequential requests, in-order responses, redirect flush.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_W        = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] FIRST_ADDRESS = '0,
    parameter int                DEPTH         = 4
) (
    input logic               clk,
    input logic               reset,
    inst_fetch_unit_if.master bus
);
    localparam int                CW         = clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
    localparam logic [DATA_W-1:0] PC_INC     = DATA_W'(FETCH_PC_INC);
    localparam logic [DATA_W-1:0] ALIGN_MASK = ~DATA_W'(3);

    logic [DATA_W-1:0] fetch_pc;
    logic [DATA_W-1:0] tag_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     occupancy;
    logic [CW-1:0]     tag_count;
    logic              req_fire;
    logic              rsp_keep;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      held;
    fetch_entry_t      shown;
    fetch_entry_t      push_entry;

    // Buffered words plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign bus.imem_req_valid = reset && !bus.redirect_valid &&
                                (occupancy + outstanding < DEPTH_C);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_keep           = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
    assign bus.inst_valid     = (occupancy != '0);
    assign pop                = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    assign push_entry         = '{pc: tag_pc, inst: bus.imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t)), .CW(CW)) u_data_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .dout  (head),
        .count (occupancy)
    );

    // Tags of requests whose responses will be kept; dropped responses never had a tag queued.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W), .CW(CW)) u_tag_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (req_fire),
        .pop   (rsp_keep),
        .flush (bus.redirect_valid),
        .din   (fetch_pc),
        .dout  (tag_pc),
        .count (tag_count)
    );

    // Output holds the last displayed entry while the FIFO is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              held <= '0;
        else if (bus.inst_valid) held <= head;
    end

    assign shown            = bus.inst_valid ? head : held;
    assign bus.inst_out     = shown.inst;
    assign bus.inst_pc      = shown.pc;
    assign bus.inst_next_pc = shown.pc + PC_INC;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= FIRST_ADDRESS;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            assert (tag_count == outstanding - drop_cnt);
            assert (!(bus.imem_rsp_valid && outstanding == '0));
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc & ALIGN_MASK;
                // A response arriving alongside the redirect is already discarded this cycle.
                drop_cnt <= outstanding - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_INC;
                if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: memory model with variable in-order latency and a queue-level reference.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH         = 4;
    localparam logic [31:0] FIRST_ADDRESS = 32'h0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_unit_if #(.DATA_W(32)) bus ();

    inst_fetch_unit #(.DATA_W(32), .FIRST_ADDRESS(FIRST_ADDRESS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: the buffered words, the tags of kept requests, and simple counters.
    fetch_entry_t m_q[$];
    logic [31:0]  m_tags[$];
    int           m_out;
    int           m_drop;
    logic [31:0]  m_pc;
    fetch_entry_t m_last;

    always @(negedge clk) begin : compare
        fetch_entry_t shown;
        fetch_entry_t entry;
        logic         has_head;
        logic         exp_req;
        if (!reset) begin
            check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
            check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check("rst_inst_out", bus.inst_out, 32'd0);
            check("rst_inst_pc", bus.inst_pc, 32'd0);
            check("rst_inst_next_pc", bus.inst_next_pc, 32'd4);
            m_q.delete();
            m_tags.delete();
            m_out  = 0;
            m_drop = 0;
            m_pc   = FIRST_ADDRESS;
            m_last = '0;
        end else begin
            has_head = (m_q.size() != 0);
            shown    = has_head ? m_q[0] : m_last;
            exp_req  = !bus.redirect_valid && (m_q.size() + m_out < DEPTH);
            check("inst_valid", 32'(bus.inst_valid), 32'(has_head));
            check("inst_pc", bus.inst_pc, shown.pc);
            check("inst_out", bus.inst_out, shown.inst);
            check("inst_next_pc", bus.inst_next_pc, shown.pc + 32'd4);
            check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            check("req_addr", bus.imem_req_addr, m_pc);
            if (has_head) check("inst_matches_memory", bus.inst_out, word_at(bus.inst_pc));

            if (has_head) m_last = m_q[0];
            if (bus.redirect_valid) begin
                m_q.delete();
                m_tags.delete();
                m_out  = m_out - int'(bus.imem_rsp_valid);
                m_drop = m_out;
                m_pc   = bus.redirect_pc & ~32'h3;
            end else begin
                if (has_head && bus.inst_ready) m_q.delete(0);
                if (bus.imem_rsp_valid) begin
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        entry.pc   = (m_tags.size() != 0) ? m_tags.pop_front() : 32'hDEAD_BEEF;
                        entry.inst = bus.imem_rsp_data;
                        m_q.push_back(entry);
                    end
                    m_out--;
                end
                if (exp_req && bus.imem_req_ready) begin
                    m_tags.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                    m_out++;
                end
            end
        end
    end

    // Instruction memory: in-order responses, per-request latency drawn from [lat_min, lat_max].
    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    pend_t pend[$];
    int    cyc      = 0;
    int    last_due = -100;
    int    lat_min  = 1;
    int    lat_max  = 1;
    int    p_ready  = 100;
    int    p_iready = 100;
    int    p_redir  = 0;

    task automatic drive();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_at(pend[0].addr);
        end
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.inst_ready     = ($urandom_range(99) < p_iready);
        bus.redirect_valid = ($urandom_range(99) < p_redir);
        bus.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                      : 32'($urandom);
    endtask

    task automatic step();
        logic        fired;
        logic        took;
        logic [31:0] addr;
        int          due;
        @(negedge clk);
        fired = reset && bus.imem_req_valid && bus.imem_req_ready;
        took  = bus.imem_rsp_valid;
        addr  = bus.imem_req_addr;
        @(posedge clk);
        #1;
        if (took && pend.size() != 0) pend.delete(0);
        if (fired) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            pend.push_back('{due, addr});
            last_due = due;
        end
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        pend.delete();
        last_due = -100;
        cyc      = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive();
    endtask

    task automatic expect_first(input string name, input logic [31:0] pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.inst_valid) begin
                seen = 1'b1;
                check({name, "_pc"}, bus.inst_pc, pc);
                check({name, "_out"}, bus.inst_out, word_at(pc));
            end else begin
                step();
                #1;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;

        // Latency 1, core always ready: streaming from the reset address.
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
        do_reset();
        #1;
        check("p1_c0_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("p1_c0_addr", bus.imem_req_addr, 32'h0);
        step(); #1;
        check("p1_c1_addr", bus.imem_req_addr, 32'h4);
        check("p1_c1_inst_valid", 32'(bus.inst_valid), 32'd0);
        step(); #1;
        check("p1_c2_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("p1_c2_inst_pc", bus.inst_pc, 32'h0);
        check("p1_c2_next_pc", bus.inst_next_pc, 32'h4);
        check("p1_c2_inst_out", bus.inst_out, word_at(32'h0));
        check("p1_c2_addr", bus.imem_req_addr, 32'h8);
        step(); #1;
        check("p1_c3_inst_pc", bus.inst_pc, 32'h4);
        repeat (20) step();

        // Core stalled: credits stop issue at DEPTH, then drain in order and resume at 0x10.
        p_iready = 0;
        do_reset();
        repeat (8) step();
        #1;
        check("p2_stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("p2_full_valid", 32'(bus.inst_valid), 32'd1);
        check("p2_model_occupancy", 32'(m_q.size()), 32'd4);
        p_iready = 100;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("p2_drain_pc", bus.inst_pc, 32'(4 * i));
            if (i == 1) begin
                check("p2_resume_valid", 32'(bus.imem_req_valid), 32'd1);
                check("p2_resume_addr", bus.imem_req_addr, 32'h10);
            end
            step(); #1;
        end

        // Latency 3, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        step(); step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        check("p3_redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
        step(); #1;
        check("p3_flushed", 32'(bus.inst_valid), 32'd0);
        expect_first("p3_first", 32'h40);

        // Redirect coinciding with a pop and a response.
        lat_min = 2; lat_max = 2;
        do_reset();
        step(); step(); step(); #1;
        check("p4_head_pc", bus.inst_pc, 32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        bus.inst_ready     = 1'b1;
        step(); #1;
        check("p4_model_drop", 32'(m_drop), 32'd1);
        check("p4_flushed", 32'(bus.inst_valid), 32'd0);
        expect_first("p4_first", 32'h80);

        // Memory not ready: address holds; misaligned redirect target is aligned.
        lat_min = 1; lat_max = 1; p_ready = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("p5_hold_addr", bus.imem_req_addr, 32'h0);
            check("p5_hold_valid", 32'(bus.imem_req_valid), 32'd1);
            step();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        step(); #1;
        check("p5_aligned_addr", bus.imem_req_addr, 32'h100);
        check("p5_aligned_valid", 32'(bus.imem_req_valid), 32'd1);

        // Asynchronous reset with three buffered entries.
        p_ready = 100; p_iready = 0;
        do_reset();
        repeat (4) step();
        #1;
        check("p6_pre_valid", 32'(bus.inst_valid), 32'd1);
        check("p6_model_occupancy", 32'(m_q.size()), 32'd3);
        reset = 1'b0;
        #1;
        check("p6_async_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("p6_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        p_iready = 100;
        do_reset();
        #1;
        check("p6_restart_addr", bus.imem_req_addr, FIRST_ADDRESS);
        check("p6_restart_valid", 32'(bus.imem_req_valid), 32'd1);

        // Random traffic: variable latency, backpressure on both sides, random redirects.
        lat_min = 1; lat_max = 5; p_ready = 70; p_iready = 70; p_redir = 4;
        do_reset();
        repeat (3000) step();

        // Sustained throughput at latency 1 with the core always ready.
        lat_min = 1; lat_max = 1; p_ready = 100; p_iready = 100; p_redir = 0;
        do_reset();
        repeat (10) step();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            cnt += int'(bus.inst_valid);
            step();
        end
        check("p8_throughput", 32'(cnt), 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
